// File: rtl/dwa_rotator.sv
// Binary code to unit-element select, either plain thermometer or data-weighted
// averaging with a rotating start pointer; all outputs registered, one cycle latency.
module dwa_rotator #(
  parameter int N_BITS = 8,
  parameter int N_ELEM = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] code_i,
  input  logic              valid_i,
  input  logic              mode_i,
  input  logic              ptr_clr_i,
  output logic [N_ELEM-1:0] sel_o,
  output logic              valid_o,
  output logic [N_BITS-1:0] ptr_o
);

  logic [N_BITS-1:0] ptr_eff;
  logic [N_BITS-1:0] base;
  logic [N_BITS-1:0] ptr_nxt;
  logic [N_ELEM-1:0] sel_nxt;

  // A clear takes effect on the pointer used by this very cycle's sample.
  assign ptr_eff = ptr_clr_i ? '0 : ptr_o;
  assign base    = mode_i ? ptr_eff : '0;
  assign ptr_nxt = (valid_i && mode_i) ? ptr_eff + code_i : ptr_eff;

  // Element i is on when its distance past the start index (mod N_ELEM) is below the code.
  always_comb begin
    sel_nxt = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      sel_nxt[i] = (N_BITS'(i) - base) < code_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_o   <= '0;
      valid_o <= 1'b0;
      ptr_o   <= '0;
    end else begin
      valid_o <= valid_i;
      ptr_o   <= ptr_nxt;
      if (valid_i) begin
        sel_o <= sel_nxt;
      end
    end
  end

endmodule

// File: doc/dwa_rotator.md
DWA_ROTATOR -- requirements
Module: dwa_rotator

Sits between the 8-bit code source and the non-overlap driver bank. Converts a binary code into a 256-element unit select using data-weighted averaging (rotating pointer) or plain thermometer.

Interface
REQ-001 Parameter N_BITS, default 8, code width.
REQ-002 Parameter N_ELEM, default 256, unit-element count (2**N_BITS).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 code_i  input  N_BITS  number of elements to enable.
REQ-006 valid_i  input  1  code_i sample strobe.
REQ-007 mode_i  input  1  0 = thermometer, 1 = DWA rotate.
REQ-008 ptr_clr_i  input  1  synchronous pointer clear.
REQ-009 sel_o  output  N_ELEM  registered unit-element select, to non-overlap stage.
REQ-010 valid_o  output  1  sel_o updated this cycle.
REQ-011 ptr_o  output  N_BITS  current rotation pointer (start index of next sample).

Function
REQ-012 sel_o, valid_o and ptr_o SHALL be registered; latency is one cycle from the valid_i edge to sel_o/valid_o.
REQ-013 valid_o SHALL equal valid_i delayed by one cycle.
REQ-014 With valid_i=0, sel_o and ptr_o SHALL hold their values.
REQ-015 Thermometer mode, valid_i=1: sel_o[i]=1 iff i < code_i; ptr_o SHALL be unchanged.
REQ-016 DWA mode, valid_i=1: sel_o[(ptr+j) mod N_ELEM]=1 for j=0..code_i-1, all other bits 0.
REQ-017 In that same DWA case, ptr_o SHALL become (ptr+code_i) mod N_ELEM, truncated to N_BITS, so wrap-around is natural.
REQ-018 code_i=0 SHALL give sel_o all zeros, with ptr_o unchanged in either mode.
REQ-019 code_i=N_ELEM-1 in DWA mode SHALL enable all elements except index (ptr-1) mod N_ELEM; ptr_o SHALL become (ptr-1) mod N_ELEM.
REQ-020 Invariant: popcount(sel_o) SHALL equal the code_i of the accepted sample.
REQ-021 ptr_clr_i=1 SHALL set the pointer used this cycle to 0.
REQ-022 ptr_clr_i=1 with valid_i=1 in DWA mode: the sample SHALL rotate from index 0, and ptr_o SHALL become code_i.
REQ-023 ptr_clr_i=1 without an accepted DWA sample: ptr_o SHALL become 0 and sel_o SHALL hold.
REQ-024 A mode_i change SHALL take effect on the next accepted sample; the pointer SHALL be retained across thermometer mode.
REQ-025 The block SHALL have no combinational path from any input to any output.

Reset
REQ-026 While rst_n=0 at a clock edge: sel_o=0, valid_o=0, ptr_o=0.
REQ-027 Reset SHALL override valid_i and ptr_clr_i.
REQ-028 A reset asserted mid-stream SHALL discard the in-flight sample; the first valid_i after release SHALL start from pointer 0.

Verification
REQ-029 Reset, then thermometer mode, code 5 -> one cycle later sel_o=0x1F, valid_o=1, ptr_o=0.
REQ-030 DWA mode, codes 3,4,2 on consecutive cycles from ptr 0:
- sel_o sequence is bits{0-2}, bits{3-6}, bits{7-8}.
- ptr_o sequence is 3, 7, 9.
REQ-031 DWA wrap: ptr 250, code 10 -> sel_o bits 250-255 and 0-3 set, ptr_o=4.
REQ-032 DWA mode, ptr 0, code 255 -> all bits except 255 set, ptr_o=255; next code 1 -> only bit 255 set, ptr_o=0.
REQ-033 ptr_o=100, ptr_clr_i=1 with valid_i=1 and code 2 -> sel_o bits 0-1 set, ptr_o=2.
REQ-034 Random stress, 10k samples in mixed modes, checked by scoreboard:
- popcount(sel_o) == code;
- the DWA enabled set is contiguous modulo 256;
- code 0 keeps ptr_o unchanged.
